// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the 4-bit FSM state codes used
// by both async_transmitter and async_receiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [3:0] {
    ST_START = 4'b0000,
    ST_IDLE  = 4'b0001,
    ST_STOP  = 4'b0010,
    ST_BIT0  = 4'b1000,
    ST_BIT1  = 4'b1001,
    ST_BIT2  = 4'b1010,
    ST_BIT3  = 4'b1011,
    ST_BIT4  = 4'b1100,
    ST_BIT5  = 4'b1101,
    ST_BIT6  = 4'b1110,
    ST_BIT7  = 4'b1111
  } uart_state_e;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: pulses bit_end on the last clk of every CLKS_PER_BIT window
// while run is high; the count restarts whenever run drops.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wrapping on bit_end makes a back-to-back STOP->START restart at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!run || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bit_end = run && (r_cnt == LAST);

endmodule

// File: rtl/async_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register so consecutive frames
// can be sent with no idle gap between them.
module async_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TxD_start,
  input  logic [DATA_BITS-1:0] TxD_data,
  output logic                 TxD,
  output logic                 TxD_ready,
  output logic                 TxD_busy,
  output logic                 TxD_done
);

  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_hold_valid;
  logic                 r_txd;
  logic                 r_done;

  logic w_bit_end;
  logic w_run;
  logic w_accept;
  logic w_load;
  logic w_shift_en;
  logic w_txd_next;
  logic w_done_next;

  assign w_run    = (r_state != ST_IDLE);
  assign w_accept = TxD_start && !r_hold_valid;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (w_run),
    .bit_end(w_bit_end)
  );

  always_comb begin
    w_state_next = r_state;
    w_txd_next   = r_txd;
    w_load       = 1'b0;
    w_shift_en   = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_txd_next = 1'b1;
        if (r_hold_valid) begin
          w_state_next = ST_START;
          w_load       = 1'b1;
          w_txd_next   = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_BIT0;
          w_txd_next   = r_shift[0];
          w_shift_en   = 1'b1;
        end
      end
      // BIT0..BIT6 codes are consecutive, so the successor is code + 1.
      ST_BIT0, ST_BIT1, ST_BIT2, ST_BIT3, ST_BIT4, ST_BIT5, ST_BIT6: begin
        if (w_bit_end) begin
          w_state_next = uart_state_e'(r_state + 4'd1);
          w_txd_next   = r_shift[0];
          w_shift_en   = 1'b1;
        end
      end
      ST_BIT7: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
          w_txd_next   = 1'b1;
        end
      end
      ST_STOP: begin
        w_txd_next = 1'b1;
        if (w_bit_end) begin
          w_done_next = 1'b1;
          if (r_hold_valid) begin
            w_state_next = ST_START;
            w_load       = 1'b1;
            w_txd_next   = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_txd   <= w_txd_next;
      r_done  <= w_done_next;
    end
  end

  // Accept and drain are mutually exclusive: accept needs an empty holder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
      r_shift      <= '0;
    end else begin
      if (w_accept) begin
        r_hold_valid <= 1'b1;
        r_hold       <= TxD_data;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
      if (w_load) begin
        r_shift <= r_hold;
      end else if (w_shift_en) begin
        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  assign TxD       = r_txd;
  assign TxD_done  = r_done;
  assign TxD_ready = !r_hold_valid;
  assign TxD_busy  = (r_state != ST_IDLE) || r_hold_valid;

endmodule

// File: tb/tb_async_transmitter.sv
// Bench for async_transmitter: one instance at 1 clk/bit, one at 4 clk/bit,
// checked against expected line waveforms built from the 8N1 frame rules.
module tb_async_transmitter;

  logic       clk;
  logic       rst;
  logic       start [2];
  logic [7:0] data  [2];
  logic       txd   [2];
  logic       ready [2];
  logic       busy  [2];
  logic       done  [2];

  int checks = 0;
  int errors = 0;

  async_transmitter #(.CLKS_PER_BIT(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .TxD_start(start[0]),
    .TxD_data (data[0]),
    .TxD      (txd[0]),
    .TxD_ready(ready[0]),
    .TxD_busy (busy[0]),
    .TxD_done (done[0])
  );

  async_transmitter #(.CLKS_PER_BIT(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .TxD_start(start[1]),
    .TxD_data (data[1]),
    .TxD      (txd[1]),
    .TxD_ready(ready[1]),
    .TxD_busy (busy[1]),
    .TxD_done (done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of frame bit b (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_txd"},   8'(txd[s]),   8'd1);
    chk({tag, "_ready"}, 8'(ready[s]), 8'd1);
    chk({tag, "_busy"},  8'(busy[s]),  8'd0);
    chk({tag, "_done"},  8'(done[s]),  8'd0);
  endtask

  task automatic send_frame(input int s, input logic [7:0] d);
    int cpb;
    cpb = (s == 0) ? 1 : 4;
    @(posedge clk); #1;
    start[s] = 1'b1;
    data[s]  = d;
    @(posedge clk); #1;              // acceptance edge k
    start[s] = 1'b0;
    data[s]  = 8'($urandom);         // must not disturb the frame
    @(negedge clk);
    chk("accept_ready", 8'(ready[s]), 8'd0);
    chk("accept_busy",  8'(busy[s]),  8'd1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(posedge clk); @(negedge clk);
        chk($sformatf("txd_bit%0d", b), 8'(txd[s]), 8'(exp_bit(d, b)));
        chk("done_in_frame", 8'(done[s]), 8'd0);
      end
    end
    @(posedge clk); @(negedge clk);
    chk("done_pulse", 8'(done[s]), 8'd1);
    @(posedge clk); @(negedge clk);
    chk_idle(s, "after_frame");
    $display("tx cpb=%0d byte=%02h", cpb, d);
  endtask

  // Two frames on the 1 clk/bit instance: second byte queued during BIT3,
  // plus a third request while the holder is full that must be ignored.
  task automatic back_to_back(input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d3;
    logic       e;
    d3 = 8'($urandom);
    @(posedge clk); #1;
    start[0] = 1'b1;
    data[0]  = d1;
    @(posedge clk); #1;              // edge k
    start[0] = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 5) begin
        start[0] = 1'b1;
        data[0]  = d2;
      end else if (cyc == 6 || cyc == 7) begin
        start[0] = 1'b1;
        data[0]  = d3;
      end else begin
        start[0] = 1'b0;
      end
      @(negedge clk);
      if (cyc <= 10)      e = exp_bit(d1, cyc - 1);
      else if (cyc <= 20) e = exp_bit(d2, cyc - 11);
      else                e = 1'b1;
      chk($sformatf("b2b_txd_c%0d", cyc), 8'(txd[0]), 8'(e));
      chk($sformatf("b2b_done_c%0d", cyc), 8'(done[0]), 8'(cyc == 11 || cyc == 21));
      chk($sformatf("b2b_busy_c%0d", cyc), 8'(busy[0]), 8'(cyc <= 20));
      if (cyc == 6 || cyc == 7) chk("b2b_ready_full", 8'(ready[0]), 8'd0);
    end
    $display("tx b2b bytes=%02h,%02h ignored=%02h", d1, d2, d3);
  endtask

  initial begin
    rst      = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    data[0]  = 8'h00;
    data[1]  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle(0, "in_reset1");
    chk_idle(1, "in_reset4");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_idle(0, "post_reset1");
    chk_idle(1, "post_reset4");
    $display("reset released");

    send_frame(0, 8'hA5);
    send_frame(1, 8'h01);
    back_to_back(8'h55, 8'hAA);
    back_to_back(8'($urandom), 8'($urandom));

    for (int n = 0; n < 6; n++) begin
      int s;
      int gap;
      s   = int'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); @(negedge clk);
        chk("gap_txd",  8'(txd[s]),  8'd1);
        chk("gap_busy", 8'(busy[s]), 8'd0);
      end
      send_frame(s, 8'($urandom));
    end

    // Reset during BIT3 with a second byte queued.
    @(posedge clk); #1;
    start[0] = 1'b1;
    data[0]  = 8'h12;
    @(posedge clk); #1;              // edge k
    start[0] = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      start[0] = (cyc == 2);
      data[0]  = 8'h34;
    end
    @(negedge clk);
    chk("pre_reset_busy",  8'(busy[0]),  8'd1);
    chk("pre_reset_ready", 8'(ready[0]), 8'd0);
    #2 rst = 1'b0;
    #1;
    chk_idle(0, "async_reset");
    $display("reset asserted mid-frame");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); @(negedge clk);
      chk_idle(0, "after_mid_reset");
    end
    send_frame(0, 8'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
